// File: rtl/gray2bin_arbiter.sv
// Round-robin arbiter feeding a single shared Gray-to-binary converter.
// One requester is accepted at a time; its result leaves on a valid/ready port tagged with its ID.

module gray2bin #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] binary_out
);

  // Each binary bit is the XOR of every Gray bit at or above it.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign binary_out[gi] = ^gray_in[WIDTH-1:gi];
  end

endmodule

module gray2bin_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_gray,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_binary,
  output logic [ID_WIDTH-1:0]           out_id,
  output logic [15:0]                   done_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                state_q;
  logic [ID_WIDTH-1:0]   rr_ptr_q;
  logic [ID_WIDTH-1:0]   rr_ptr_d;
  logic [DATA_WIDTH-1:0] hold_gray_q;
  logic [ID_WIDTH-1:0]   hold_id_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_binary_q;
  logic [ID_WIDTH-1:0]   out_id_q;
  logic [15:0]           done_count_q;

  logic                  grant_found;
  logic [ID_WIDTH-1:0]   grant_id;
  logic [DATA_WIDTH-1:0] sel_gray;
  logic [DATA_WIDTH-1:0] conv_binary;

  // Search starts at rr_ptr and wraps, so the last-served requester goes to the back.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      idx = (int'(rr_ptr_q) + j) % NUM_REQ;
      if (!grant_found && req_valid[ID_WIDTH'(idx)]) begin
        grant_found = 1'b1;
        grant_id    = ID_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && grant_found) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign sel_gray = req_gray[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign rr_ptr_d = (hold_id_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : hold_id_q + 1'b1;

  gray2bin #(
    .WIDTH (DATA_WIDTH)
  ) u_conv (
    .gray_in    (hold_gray_q),
    .binary_out (conv_binary)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      hold_gray_q  <= '0;
      hold_id_q    <= '0;
      out_valid_q  <= 1'b0;
      out_binary_q <= '0;
      out_id_q     <= '0;
      done_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            hold_gray_q <= sel_gray;
            hold_id_q   <= grant_id;
            state_q     <= CONV;
          end
        end
        CONV: begin
          out_binary_q <= conv_binary;
          out_id_q     <= hold_id_q;
          out_valid_q  <= 1'b1;
          state_q      <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q  <= 1'b0;
            done_count_q <= done_count_q + 16'd1;
            rr_ptr_q     <= rr_ptr_d;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_binary = out_binary_q;
  assign out_id     = out_id_q;
  assign done_count = done_count_q;

endmodule

// File: tb/tb_gray2bin_arbiter.sv
// Directed bench for gray2bin_arbiter: hand-computed Gray conversions, grant order and handshake.
// Inputs change and outputs are sampled on the falling edge.

module tb_gray2bin_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_gray;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_binary;
  logic [1:0]  out_id;
  logic [15:0] done_count;

  int errors = 0;
  int checks = 0;

  gray2bin_arbiter #(
    .DATA_WIDTH (8),
    .NUM_REQ    (4),
    .ID_WIDTH   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_gray   (req_gray),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_binary (out_binary),
    .out_id     (out_id),
    .done_count (done_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starts in IDLE at a falling edge with requests already driven and out_ready=1.
  task automatic txn(input string tag, input logic [3:0] exp_ready, input logic [1:0] exp_id,
                     input logic [7:0] exp_bin, input logic [15:0] exp_done);
    #1;
    check({tag, " req_ready"}, 32'(req_ready), 32'(exp_ready));
    step();
    check({tag, " conv req_ready"}, 32'(req_ready), 32'h0);
    check({tag, " conv out_valid"}, 32'(out_valid), 32'h0);
    step();
    check({tag, " out_valid"}, 32'(out_valid), 32'h1);
    check({tag, " out_binary"}, 32'(out_binary), 32'(exp_bin));
    check({tag, " out_id"}, 32'(out_id), 32'(exp_id));
    step();
    check({tag, " done_count"}, 32'(done_count), 32'(exp_done));
    $display("txn %s: id=%0d binary=%02h done=%0d", tag, exp_id, exp_bin, exp_done);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_gray  = 32'h0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst out_valid", 32'(out_valid), 32'h0);
    check("rst out_binary", 32'(out_binary), 32'h0);
    check("rst out_id", 32'(out_id), 32'h0);
    check("rst done_count", 32'(done_count), 32'h0);
    check("rst req_ready", 32'(req_ready), 32'h0);
    rst_n = 1'b1;
    step();
    check("idle no req", 32'(req_ready), 32'h0);

    // Single requester, 0x55 -> 0x66
    req_valid = 4'b0001;
    req_gray  = 32'h0000_0055;
    #1;
    check("t1 req_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 4'b0000;
    check("t1 conv out_valid", 32'(out_valid), 32'h0);
    step();
    check("t1 out_valid", 32'(out_valid), 32'h1);
    check("t1 out_binary", 32'(out_binary), 32'h66);
    check("t1 out_id", 32'(out_id), 32'h0);
    step();
    check("t1 out_valid low", 32'(out_valid), 32'h0);
    check("t1 done_count", 32'(done_count), 32'h1);

    // All requesting: round-robin 0,1,2,3,0
    do_reset();
    req_gray  = {8'h55, 8'h57, 8'h80, 8'h00};
    req_valid = 4'b1111;
    txn("t2a", 4'b0001, 2'd0, 8'h00, 16'd1);
    txn("t2b", 4'b0010, 2'd1, 8'hFF, 16'd2);
    txn("t2c", 4'b0100, 2'd2, 8'h65, 16'd3);
    txn("t2d", 4'b1000, 2'd3, 8'h66, 16'd4);
    txn("t2e", 4'b0001, 2'd0, 8'h00, 16'd5);

    // Backpressure: result held for 5 cycles while out_ready=0
    req_valid = 4'b0100;
    out_ready = 1'b0;
    #1;
    check("t3 req_ready", 32'(req_ready), 32'h4);
    step();
    step();
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3 hold out_valid", 32'(out_valid), 32'h1);
      check("t3 hold out_binary", 32'(out_binary), 32'h65);
      check("t3 hold out_id", 32'(out_id), 32'h2);
      check("t3 hold req_ready", 32'(req_ready), 32'h0);
      check("t3 hold done_count", 32'(done_count), 32'd5);
    end
    out_ready = 1'b1;
    step();
    check("t3 release out_valid", 32'(out_valid), 32'h0);
    check("t3 release done_count", 32'(done_count), 32'd6);
    $display("txn t3: id=2 binary=65 held 5 cycles done=6");

    // Wrap-around: after id 1, rr_ptr=2, requests {0,1} grant 0
    req_valid = 4'b0010;
    txn("t4a", 4'b0010, 2'd1, 8'hFF, 16'd7);
    req_valid = 4'b0011;
    txn("t4b", 4'b0001, 2'd0, 8'h00, 16'd8);

    // Asynchronous reset while in CONV
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    check("t5 async out_valid", 32'(out_valid), 32'h0);
    check("t5 async done_count", 32'(done_count), 32'h0);
    check("t5 async req_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check("t5 idle out_valid", 32'(out_valid), 32'h0);
    req_valid = 4'b0110;
    txn("t5", 4'b0010, 2'd1, 8'hFF, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
